// File: rtl/local_coincidence_nbr.sv
// Per-channel retriggerable coincidence windows with global or neighbourhood
// open-window counting, a per-channel coincidence flag, a registered global OR
// and a saturating count of coincidence events.
module local_coincidence_nbr #(
    parameter int unsigned N_CHANNELS = 24,
    parameter int unsigned WIN_W      = 16,
    parameter int unsigned THR_W      = 16,
    parameter int unsigned SPAN_W     = 5,
    parameter int unsigned EVT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIN_W-1:0]      lc_window_width,
    input  logic [THR_W-1:0]      n_lc_thr,
    input  logic                  lc_mode,
    input  logic [SPAN_W-1:0]     lc_span,
    input  logic [N_CHANNELS-1:0] chan_mask,
    input  logic [N_CHANNELS-1:0] trig,
    input  logic                  lc_evt_clr,
    output logic [N_CHANNELS-1:0] local_coinc,
    output logic                  lc_any,
    output logic [EVT_W-1:0]      lc_evt_cnt
);

    localparam int unsigned CNT_W = $clog2(N_CHANNELS + 1);
    localparam int unsigned CMP_W = (CNT_W > THR_W) ? CNT_W : THR_W;

    logic [N_CHANNELS-1:0] trig_q, trig_d;
    logic [N_CHANNELS-1:0] trig_qq_q, trig_qq_d;
    logic [WIN_W-1:0]      win_cnt_q [N_CHANNELS];
    logic [WIN_W-1:0]      win_cnt_d [N_CHANNELS];
    logic [N_CHANNELS-1:0] local_coinc_q, local_coinc_d;
    logic                  lc_any_q, lc_any_d;
    logic                  lc_any_dly_q, lc_any_dly_d;
    logic [EVT_W-1:0]      lc_evt_cnt_q, lc_evt_cnt_d;

    logic [N_CHANNELS-1:0] edge_det;
    logic [N_CHANNELS-1:0] win_open;
    logic [CNT_W-1:0]      cnt;
    logic                  in_nbr;
    logic                  thr_en;

    // Input synchroniser stage and masked rising-edge detection.
    always_comb begin
        trig_d    = trig;
        trig_qq_d = trig_q;
        edge_det  = trig_q & ~trig_qq_q & chan_mask;
    end

    // Window counters: mask clears, an edge reloads the full width, else count down.
    always_comb begin
        for (int i = 0; i < int'(N_CHANNELS); i++) begin
            win_open[i] = (win_cnt_q[i] != '0);
            if (!chan_mask[i]) begin
                win_cnt_d[i] = '0;
            end else if (edge_det[i]) begin
                win_cnt_d[i] = lc_window_width;
            end else if (win_open[i]) begin
                win_cnt_d[i] = win_cnt_q[i] - WIN_W'(1);
            end else begin
                win_cnt_d[i] = win_cnt_q[i];
            end
        end
    end

    // Open-window count per channel (whole array or +/-span, no wrap) and threshold.
    always_comb begin
        local_coinc_d = '0;
        cnt           = '0;
        in_nbr        = 1'b0;
        thr_en        = (n_lc_thr != '0);
        for (int i = 0; i < int'(N_CHANNELS); i++) begin
            cnt = '0;
            for (int j = 0; j < int'(N_CHANNELS); j++) begin
                in_nbr = !lc_mode ||
                         ((j >= i - int'(lc_span)) && (j <= i + int'(lc_span)));
                if (in_nbr && win_open[j]) begin
                    cnt = cnt + CNT_W'(1);
                end
            end
            local_coinc_d[i] = win_open[i] && thr_en &&
                               (CMP_W'(cnt) >= CMP_W'(n_lc_thr));
        end
    end

    // Global OR and event counter; clear has priority over an increment.
    always_comb begin
        lc_any_d     = |local_coinc_d;
        lc_any_dly_d = lc_any_q;
        lc_evt_cnt_d = lc_evt_cnt_q;
        if (lc_evt_clr) begin
            lc_evt_cnt_d = '0;
        end else if (lc_any_q && !lc_any_dly_q && (lc_evt_cnt_q != '1)) begin
            lc_evt_cnt_d = lc_evt_cnt_q + EVT_W'(1);
        end
    end

    // State registers, cleared asynchronously while rst is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            trig_q        <= '0;
            trig_qq_q     <= '0;
            local_coinc_q <= '0;
            lc_any_q      <= 1'b0;
            lc_any_dly_q  <= 1'b0;
            lc_evt_cnt_q  <= '0;
            for (int i = 0; i < int'(N_CHANNELS); i++) begin
                win_cnt_q[i] <= '0;
            end
        end else begin
            trig_q        <= trig_d;
            trig_qq_q     <= trig_qq_d;
            local_coinc_q <= local_coinc_d;
            lc_any_q      <= lc_any_d;
            lc_any_dly_q  <= lc_any_dly_d;
            lc_evt_cnt_q  <= lc_evt_cnt_d;
            for (int i = 0; i < int'(N_CHANNELS); i++) begin
                win_cnt_q[i] <= win_cnt_d[i];
            end
        end
    end

    assign local_coinc = local_coinc_q;
    assign lc_any      = lc_any_q;
    assign lc_evt_cnt  = lc_evt_cnt_q;

endmodule

// File: tb/tb_local_coincidence_nbr.sv
// Directed bench for local_coincidence_nbr (EVT_W=4 build so saturation is reachable).
module tb_local_coincidence_nbr;

    localparam int unsigned N      = 24;
    localparam int unsigned WIN_W  = 16;
    localparam int unsigned THR_W  = 16;
    localparam int unsigned SPAN_W = 5;
    localparam int unsigned EVT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [WIN_W-1:0]  lc_window_width;
    logic [THR_W-1:0]  n_lc_thr;
    logic              lc_mode;
    logic [SPAN_W-1:0] lc_span;
    logic [N-1:0]      chan_mask;
    logic [N-1:0]      trig;
    logic              lc_evt_clr;
    logic [N-1:0]      local_coinc;
    logic              lc_any;
    logic [EVT_W-1:0]  lc_evt_cnt;

    int vectors = 0;
    int miscompares = 0;

    local_coincidence_nbr #(
        .N_CHANNELS(N),
        .WIN_W     (WIN_W),
        .THR_W     (THR_W),
        .SPAN_W    (SPAN_W),
        .EVT_W     (EVT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .lc_window_width(lc_window_width),
        .n_lc_thr       (n_lc_thr),
        .lc_mode        (lc_mode),
        .lc_span        (lc_span),
        .chan_mask      (chan_mask),
        .trig           (trig),
        .lc_evt_clr     (lc_evt_clr),
        .local_coinc    (local_coinc),
        .lc_any         (lc_any),
        .lc_evt_cnt     (lc_evt_cnt)
    );

    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit after the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_cnt();
        lc_evt_clr = 1'b1;
        step(1);
        lc_evt_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; trig = '0; lc_evt_clr = 1'b0;
        lc_window_width = 16'd9; n_lc_thr = 16'd4; lc_mode = 1'b0; lc_span = '0;
        chan_mask = '1;
        step(3);
        rst = 1'b1;
        for (int k = 0; k < 50; k++) begin
            step(1);
            vectors++;
            if (local_coinc !== '0 || lc_any !== 1'b0 || lc_evt_cnt !== '0) begin
                miscompares++;
                $display("FAIL reset_idle k=%0d: got lc=%h any=%b cnt=%0d want 0/0/0",
                         k, local_coinc, lc_any, lc_evt_cnt);
            end
        end
    endtask

    task automatic test_global_burst();
        logic [N-1:0] exp;
        clear_cnt();
        for (int k = 0; k <= 12; k++) begin
            trig = 24'h00000F;          // sampled at edge n (k=0)
            step(1);
            exp = (k >= 2 && k <= 10) ? 24'h00000F : 24'h0;
            vectors++;
            if (local_coinc !== exp || lc_any !== (|exp)) begin
                miscompares++;
                $display("FAIL global_burst k=%0d: got lc=%h any=%b want lc=%h any=%b",
                         k, local_coinc, lc_any, exp, |exp);
            end
        end
        trig = '0;
        step(3);
        vectors++;
        if (lc_evt_cnt !== 4'd1) begin
            miscompares++;
            $display("FAIL global_evt_cnt: got %0d want 1", lc_evt_cnt);
        end
    endtask

    task automatic test_staggered();
        logic [N-1:0] exp;
        clear_cnt();
        trig = '0;
        for (int k = 0; k <= 16; k++) begin
            if (k == 0) trig = 24'h000001;
            if (k == 5) trig = 24'h00000F;
            step(1);
            exp = (k >= 7 && k <= 10) ? 24'h00000F : 24'h0;
            vectors++;
            if (local_coinc !== exp) begin
                miscompares++;
                $display("FAIL staggered k=%0d: got %h want %h", k, local_coinc, exp);
            end
        end
        trig = '0;
        step(3);
        vectors++;
        if (lc_evt_cnt !== 4'd1) begin
            miscompares++;
            $display("FAIL staggered_evt_cnt: got %0d want 1", lc_evt_cnt);
        end
    endtask

    task automatic test_neighbourhood();
        logic [N-1:0] pat [3];
        logic [N-1:0] hit [3];
        logic [N-1:0] exp;
        pat[0] = 24'h000021; hit[0] = 24'h000000;
        pat[1] = 24'h000060; hit[1] = 24'h000060;
        pat[2] = 24'h800001; hit[2] = 24'h000000;
        lc_mode = 1'b1; lc_span = 5'd1; n_lc_thr = 16'd2; lc_window_width = 16'd5;
        for (int p = 0; p < 3; p++) begin
            trig = '0;
            step(8);
            for (int k = 0; k <= 9; k++) begin
                trig = pat[p];
                step(1);
                exp = (k >= 2 && k <= 6) ? hit[p] : 24'h0;
                vectors++;
                if (local_coinc !== exp) begin
                    miscompares++;
                    $display("FAIL nbr p=%0d k=%0d: got %h want %h", p, k, local_coinc, exp);
                end
            end
        end
        trig = '0;
        lc_mode = 1'b0; lc_span = '0;
        step(8);
    endtask

    task automatic test_mask();
        logic [N-1:0] exp;
        lc_window_width = 16'd9; n_lc_thr = 16'd4;
        chan_mask = ~24'h000004;
        for (int k = 0; k <= 12; k++) begin
            trig = 24'h00000F;
            if (k == 3) n_lc_thr = 16'd3;
            if (k == 6) chan_mask = ~24'h000005;
            step(1);
            exp = (k >= 3 && k <= 6) ? 24'h00000B : 24'h0;
            vectors++;
            if (local_coinc !== exp) begin
                miscompares++;
                $display("FAIL mask k=%0d: got %h want %h", k, local_coinc, exp);
            end
        end
        trig = '0; chan_mask = '1; n_lc_thr = 16'd4;
        step(12);
    endtask

    task automatic test_async_reset();
        lc_window_width = 16'd9; n_lc_thr = 16'd4; lc_mode = 1'b0; chan_mask = '1;
        trig = 24'h00000F;
        step(4);
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (local_coinc !== '0 || lc_any !== 1'b0 || lc_evt_cnt !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got lc=%h any=%b cnt=%0d want 0/0/0",
                     local_coinc, lc_any, lc_evt_cnt);
        end
        #1 rst = 1'b1;                  // trig still high: next edge sees a fresh rise
        step(3);
        vectors++;
        if (local_coinc !== 24'h00000F) begin
            miscompares++;
            $display("FAIL reset_rearm: got %h want %h", local_coinc, 24'h00000F);
        end
        trig = '0;
        step(12);
    endtask

    task automatic test_back_to_back();
        logic [EVT_W-1:0] exp;
        clear_cnt();
        lc_window_width = 16'd2; n_lc_thr = 16'd1; chan_mask = '1; lc_mode = 1'b0;
        for (int b = 0; b < 16; b++) begin
            trig = 24'h000001;
            step(1);
            trig = '0;
            step(7);
            exp = (b + 1 > 15) ? 4'd15 : 4'(b + 1);
            vectors++;
            if (lc_evt_cnt !== exp) begin
                miscompares++;
                $display("FAIL saturate b=%0d: got %0d want %0d", b, lc_evt_cnt, exp);
            end
        end
        // Clear coincides with the increment edge (n+3) of a new burst.
        trig = 24'h000001;
        step(1);
        trig = '0;
        step(1);
        vectors++;
        if (lc_any !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_pre_any: got %b want 0", lc_any);
        end
        step(1);
        vectors++;
        if (lc_any !== 1'b1 || lc_evt_cnt !== 4'd15) begin
            miscompares++;
            $display("FAIL clr_rise: got any=%b cnt=%0d want 1/15", lc_any, lc_evt_cnt);
        end
        lc_evt_clr = 1'b1;
        step(1);
        lc_evt_clr = 1'b0;
        vectors++;
        if (lc_evt_cnt !== 4'd0) begin
            miscompares++;
            $display("FAIL clr_wins: got %0d want 0", lc_evt_cnt);
        end
        step(4);
        vectors++;
        if (lc_evt_cnt !== 4'd0) begin
            miscompares++;
            $display("FAIL clr_hold: got %0d want 0", lc_evt_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_global_burst();
        test_staggered();
        test_neighbourhood();
        test_mask();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/local_coincidence_nbr.md
Name: local_coincidence_nbr

Overview:
- Parametrised successor to the channel local-coincidence block: per-channel retriggerable coincidence windows, open-window counting, and a per-channel coincidence flag.
- Adds a neighbourhood mode (count only channels within ±lc_span), a per-channel enable mask, registered global OR output, and a saturating coincidence-event counter.
- Sits between the per-channel discriminator trigger outputs and the readout/trigger-decision logic.

Parameters:
N_CHANNELS, 24, number of trigger channels (2..64)
WIN_W, 16, width of lc_window_width and the per-channel window counters
THR_W, 16, width of n_lc_thr
SPAN_W, 5, width of lc_span
EVT_W, 32, width of lc_evt_cnt

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  reset, asynchronous assert, active-low (0 = reset); all registers cleared while low
lc_window_width  in  WIN_W  window length in clk cycles; 0 disables windows
n_lc_thr  in  THR_W  required open-window count; 0 disables the block
lc_mode  in  1  0 = global count, 1 = neighbourhood count
lc_span  in  SPAN_W  neighbourhood half-width, channels, used when lc_mode=1
chan_mask  in  N_CHANNELS  1 = channel enabled
trig  in  N_CHANNELS  discriminator levels, synchronous to clk
lc_evt_clr  in  1  synchronous clear of lc_evt_cnt
local_coinc  out  N_CHANNELS  per-channel coincidence flag, registered
lc_any  out  1  OR of next-state local_coinc, registered
lc_evt_cnt  out  EVT_W  count of lc_any rising edges, saturating

Behaviour:
- Reset (rst=0): trig_q, trig_qq, win_cnt[*], local_coinc, lc_any, lc_any_q, lc_evt_cnt all 0.
- Input stage: trig_q <= trig; trig_qq <= trig_q. edge[i] = trig_q[i] & ~trig_qq[i] & chan_mask[i].
- Define cycle n as the clock edge where trig[i]=1 is first sampled into trig_q.
- Window counter per channel:
  - chan_mask[i]=0: win_cnt[i] <= 0. Masking mid-window closes that window on the next edge.
  - Else if edge[i]: win_cnt[i] <= lc_window_width. Retrigger reloads full width; no accumulation.
  - Else if win_cnt[i] != 0: decrement.
  - open[i] = (win_cnt[i] != 0). Open after edges n+1 .. n+W, i.e. exactly W cycles.
- Level held high creates one edge only. Re-arming needs trig low for at least one sampled cycle.
- Count:
  - lc_mode=0: cnt_i = popcount(open) for all i.
  - lc_mode=1: cnt_i = popcount(open[j]) for max(0, i-span) <= j <= min(N-1, i+span). No wrap-around; channel 0 and N-1 are not neighbours. The channel itself is included.
  - Width is clog2(N_CHANNELS+1); compare zero-extended against n_lc_thr.
- Output:
  - local_coinc[i] <= open[i] & (n_lc_thr != 0) & (cnt_i >= n_lc_thr). Combinational count, single register stage.
  - Flag is visible after edge n+2 at earliest; total latency trig→local_coinc is 2 clocks after sampling.
  - lc_any <= |(next local_coinc). lc_any therefore tracks |local_coinc exactly, same cycle.
- n_lc_thr > N_CHANNELS (or > 2*span+1 in mode 1): outputs never assert. n_lc_thr = 1: any open window flags itself.
- Event counter (priority order):
  - lc_any_q <= lc_any.
  - lc_evt_clr=1: lc_evt_cnt <= 0. Clear wins over a simultaneous increment.
  - Else if lc_any & ~lc_any_q & (lc_evt_cnt != all-ones): increment.
  - Saturates at 2^EVT_W-1.
- Config change (width, thr, mode, span) takes effect on the next edge. Running counters are not reloaded; a width change applies only to subsequent edges.
- Reset asserted mid-window: all state cleared immediately (async). Edges after release are detected fresh. A trig already high at release counts as a rising edge on the first sampled cycle.

Test Plan:
- Reset release, trig=0 throughout, W=9, thr=4 -> local_coinc=0, lc_any=0, lc_evt_cnt=0 for 50 cycles.
- W=9, thr=4, mode 0, mask=all-ones; trig[3:0]=4'hF rise at cycle n -> local_coinc[3:0]=4'hF after edges n+2..n+10 (9 cycles), other bits 0, lc_evt_cnt=1.
- W=9, thr=4, mode 0; trig[0] rises at n, trig[3:1] rise at n+5 -> local_coinc[3:0]=4'hF after edges n+7..n+10 only (4 cycles), then 0; lc_evt_cnt=1.
- Mode 1, span=1, thr=2, W=5; trig[0]&trig[5] at n -> no flags. trig[5]&trig[6] at m -> only bits 5,6 high for 5 cycles. trig[0]&trig[23] -> no flags (no wrap).
- mask bit 2 = 0, trig[3:0] rise, thr=4 -> no flags. Set thr=3 -> bits 0,1,3 high, bit 2 low. Clear mask mid-window -> that channel's open drops the next cycle.
- Force lc_evt_cnt near saturation (EVT_W=4 build): 16 coincidence bursts -> holds at 15. Assert lc_evt_clr on the same cycle as an lc_any rise -> count=0.
